// File: rtl/main_memory_if.sv
// L2-facing request/response bus of the main memory block.
// One shared word address serves both the read and the write strobe.
interface main_memory_if #(
  parameter int n      = 32,
  parameter int addr_w = 10
);
  logic [addr_w-1:0] MM_word_address;
  logic [n-1:0]      MM_write_word;
  logic              MM_read_request;
  logic              MM_write_request;
  logic [n-1:0]      MM_read_word;

  modport master (
    output MM_word_address, MM_write_word, MM_read_request, MM_write_request,
    input  MM_read_word
  );

  modport slave (
    input  MM_word_address, MM_write_word, MM_read_request, MM_write_request,
    output MM_read_word
  );
endinterface

// File: rtl/main_memory.sv
// Backing store behind the L2: single-port word array plus a posted write buffer
// drained in read-free cycles. Optional per-word parity with `define MM_PARITY_EN.
module main_memory #(
  parameter int n        = 32,
  parameter int addr_w   = 10,
  parameter int WB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  main_memory_if.slave               mm,
  output logic [$clog2(WB_DEPTH):0]  wb_count,
  output logic                       wb_overflow,
  output logic                       mm_parity_error,
  output logic [31:0]                MM_statistics
);
  localparam int PW    = $clog2(WB_DEPTH);
  localparam int DEPTH = 1 << addr_w;

  typedef enum logic [1:0] {WB_EMPTY, WB_PARTIAL, WB_FULL} wb_state_e;

  logic [n-1:0]      r_mem     [DEPTH];
  logic [addr_w-1:0] r_wb_addr [WB_DEPTH];
  logic [n-1:0]      r_wb_data [WB_DEPTH];
  logic [PW:0]       r_head;
  logic [PW:0]       r_tail;
  logic [n-1:0]      r_read_word;
  logic              r_overflow;
  logic [15:0]       r_rd_cnt;
  logic [15:0]       r_wr_cnt;

  wb_state_e         w_state;
  logic [PW:0]       w_count;
  logic [PW-1:0]     w_head_idx;
  logic [PW-1:0]     w_tail_idx;
  logic [addr_w-1:0] w_addr;
  logic              w_rd;
  logic              w_wr;
  logic              w_drain;
  logic              w_enq;
  logic              w_same;
  logic              w_fwd_hit;
  logic [n-1:0]      w_fwd_data;
  logic [n-1:0]      w_rd_data;

  assign w_rd       = mm.MM_read_request;
  assign w_wr       = mm.MM_write_request;
  assign w_addr     = mm.MM_word_address;
  assign w_count    = r_tail - r_head;
  assign w_head_idx = r_head[PW-1:0];
  assign w_tail_idx = r_tail[PW-1:0];

  // Equal indices mean empty or full; the wrap bit tells which.
  always_comb begin
    w_state = WB_PARTIAL;
    if (r_head == r_tail)
      w_state = WB_EMPTY;
    else if (w_head_idx == w_tail_idx)
      w_state = WB_FULL;
  end

  always_comb begin
    w_drain = !w_rd && (w_state != WB_EMPTY);
    w_enq   = w_wr && ((w_state != WB_FULL) || w_drain);
    // Read and write share one address, so both strobes always mean a same-address hit.
    w_same  = w_wr;
  end

  // Oldest-to-youngest scan so the last match left standing is the youngest write.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if (((PW+1)'(i) < w_count) && (r_wb_addr[w_head_idx + PW'(i)] == w_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wb_data[w_head_idx + PW'(i)];
      end
    end
  end

  always_comb begin
    w_rd_data = r_mem[w_addr];
    if (w_same)
      w_rd_data = mm.MM_write_word;
    else if (w_fwd_hit)
      w_rd_data = w_fwd_data;
  end

  always_ff @(posedge clk) begin
    if (w_drain)
      r_mem[r_wb_addr[w_head_idx]] <= r_wb_data[w_head_idx];
    if (w_enq) begin
      r_wb_addr[w_tail_idx] <= w_addr;
      r_wb_data[w_tail_idx] <= mm.MM_write_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_read_word <= '0;
      r_overflow  <= 1'b0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
    end else begin
      if (w_rd) begin
        r_read_word <= w_rd_data;
        r_rd_cnt    <= r_rd_cnt + 16'd1;
      end
      if (w_wr)
        r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_wr && !w_enq)
        r_overflow <= 1'b1;
      if (w_drain)
        r_head <= r_head + (PW+1)'(1);
      if (w_enq)
        r_tail <= r_tail + (PW+1)'(1);
    end
  end

`ifdef MM_PARITY_EN
  logic r_par [DEPTH];
  logic r_parity_error;
  logic w_par_err;

  always_ff @(posedge clk) begin
    if (w_drain)
      r_par[r_wb_addr[w_head_idx]] <= ^r_wb_data[w_head_idx];
  end

  // Only array-sourced reads are checked; never-written words carry unknown parity.
  assign w_par_err = w_rd && !w_same && !w_fwd_hit && !$isunknown(r_par[w_addr]) &&
                     ((^r_mem[w_addr]) != r_par[w_addr]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_parity_error <= 1'b0;
    else if (w_par_err)
      r_parity_error <= 1'b1;
  end

  assign mm_parity_error = r_parity_error;
`else
  assign mm_parity_error = 1'b0;
`endif

  assign mm.MM_read_word = r_read_word;
  assign wb_count        = w_count;
  assign wb_overflow     = r_overflow;
  assign MM_statistics   = {r_rd_cnt, r_wr_cnt};
endmodule

// File: tb/tb_main_memory.sv
// Self-checking bench for main_memory: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_main_memory;
  localparam int N   = 32;
  localparam int AW  = 10;
  localparam int WBD = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [$clog2(WBD):0]  wb_count;
  logic                  wb_overflow;
  logic                  mm_parity_error;
  logic [31:0]           MM_statistics;

  main_memory_if #(.n(N), .addr_w(AW)) bus ();

  main_memory #(.n(N), .addr_w(AW), .WB_DEPTH(WBD)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .mm              (bus),
    .wb_count        (wb_count),
    .wb_overflow     (wb_overflow),
    .mm_parity_error (mm_parity_error),
    .MM_statistics   (MM_statistics)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [N-1:0]  d;
  } wr_t;

  wr_t          m_q[$];
  logic [N-1:0] m_mem   [1<<AW];
  bit           m_known [1<<AW];
  logic [N-1:0] m_rword;
  bit           m_rknown;
  bit           m_ovf;
  int unsigned  m_rc;
  int unsigned  m_wc;

  function automatic void model_reset();
    m_q.delete();
    m_rword  = '0;
    m_rknown = 1'b1;
    m_ovf    = 1'b0;
    m_rc     = 0;
    m_wc     = 0;
  endfunction

  function automatic void model_step(bit rd, bit wr, logic [AW-1:0] a, logic [N-1:0] d);
    bit hit;
    hit = 1'b0;
    if (rd) begin
      m_rc = (m_rc + 1) % 65536;
      if (wr) begin
        m_rword  = d;
        m_rknown = 1'b1;
      end else begin
        for (int k = m_q.size() - 1; k >= 0; k--)
          if (!hit && m_q[k].a == a) begin
            m_rword = m_q[k].d;
            hit     = 1'b1;
          end
        if (hit) m_rknown = 1'b1;
        else begin
          m_rword  = m_mem[a];
          m_rknown = m_known[a];
        end
      end
    end
    if (!rd && m_q.size() > 0) begin
      m_mem[m_q[0].a]   = m_q[0].d;
      m_known[m_q[0].a] = 1'b1;
      void'(m_q.pop_front());
    end
    if (wr) begin
      m_wc = (m_wc + 1) % 65536;
      if (m_q.size() < WBD) m_q.push_back('{a, d});
      else m_ovf = 1'b1;
    end
  endfunction

  task automatic cyc(bit rd, bit wr, logic [AW-1:0] a, logic [N-1:0] d);
    bus.MM_read_request  = rd;
    bus.MM_write_request = wr;
    bus.MM_word_address  = a;
    bus.MM_write_word    = d;
    model_step(rd, wr, a, d);
    @(posedge clk);
    #1;
    bus.MM_read_request  = 1'b0;
    bus.MM_write_request = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #3;
    total++; if (bus.MM_read_word !== '0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", bus.MM_read_word); end
    total++; if (wb_count !== '0) begin bad++; $display("FAIL reset_count: got %0d exp 0", wb_count); end
    total++; if (wb_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b exp 0", wb_overflow); end
    total++; if (mm_parity_error !== 1'b0) begin bad++; $display("FAIL reset_par: got %b exp 0", mm_parity_error); end
    total++; if (MM_statistics !== '0) begin bad++; $display("FAIL reset_stats: got %h exp 0", MM_statistics); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_read();
    cyc(0, 1, AW'('h155), 32'hDEADBEEF);
    total++; if (wb_count !== 3'd1) begin bad++; $display("FAIL basic_count1: got %0d exp 1", wb_count); end
    repeat (5) cyc(0, 0, '0, '0);
    total++; if (wb_count !== 3'd0) begin bad++; $display("FAIL basic_count0: got %0d exp 0", wb_count); end
    cyc(1, 0, AW'('h155), '0);
    total++; if (bus.MM_read_word !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rdata: got %h exp deadbeef", bus.MM_read_word); end
    total++; if (MM_statistics !== 32'h0001_0001) begin bad++; $display("FAIL basic_stats: got %h exp 00010001", MM_statistics); end
  endtask

  task automatic test_refill_burst();
    for (int i = 0; i < 4; i++) cyc(0, 1, AW'('h100 + i), N'('hA0 + i));
    repeat (2) cyc(0, 0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, AW'('h100 + i), '0);
      total++;
      if (bus.MM_read_word !== N'('hA0 + i)) begin
        bad++; $display("FAIL burst_rdata%0d: got %h exp %h", i, bus.MM_read_word, N'('hA0 + i));
      end
    end
  endtask

  task automatic test_forwarding();
    cyc(1, 1, AW'('h3F0), N'('h11));
    cyc(1, 1, AW'('h3F0), N'('h22));
    cyc(1, 0, AW'('h3F0), '0);
    total++; if (bus.MM_read_word !== N'('h22)) begin bad++; $display("FAIL fwd_rdata: got %h exp 22", bus.MM_read_word); end
    total++; if (wb_count !== 3'd2) begin bad++; $display("FAIL fwd_count2: got %0d exp 2", wb_count); end
    cyc(0, 0, '0, '0);
    total++; if (wb_count !== 3'd1) begin bad++; $display("FAIL fwd_count1: got %0d exp 1", wb_count); end
    cyc(0, 0, '0, '0);
    total++; if (wb_count !== 3'd0) begin bad++; $display("FAIL fwd_count0: got %0d exp 0", wb_count); end
    cyc(1, 0, AW'('h3F0), '0);
    total++; if (bus.MM_read_word !== N'('h22)) begin bad++; $display("FAIL fwd_array: got %h exp 22", bus.MM_read_word); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_stats;
    cyc(0, 1, AW'(4), N'('h4444));
    repeat (3) cyc(0, 0, '0, '0);
    for (int i = 0; i <= WBD; i++) cyc(1, 1, AW'(i), N'('h500 + i));
    total++; if (wb_count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d exp 4", wb_count); end
    total++; if (wb_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b exp 1", wb_overflow); end
    exp_stats = {m_rc[15:0], m_wc[15:0]};
    total++; if (MM_statistics !== exp_stats) begin bad++; $display("FAIL ovf_stats: got %h exp %h", MM_statistics, exp_stats); end
    repeat (6) cyc(0, 0, '0, '0);
    cyc(1, 0, AW'(4), '0);
    total++; if (bus.MM_read_word !== N'('h4444)) begin bad++; $display("FAIL ovf_lost: got %h exp 4444", bus.MM_read_word); end
    cyc(1, 0, AW'(3), '0);
    total++; if (bus.MM_read_word !== N'('h503)) begin bad++; $display("FAIL ovf_kept: got %h exp 503", bus.MM_read_word); end
  endtask

  task automatic test_full_no_read();
    pulse_reset();
    total++; if (wb_overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_clr: got %b exp 0", wb_overflow); end
    for (int i = 0; i < WBD; i++) cyc(1, 1, AW'('h20 + i), N'('hC0 + i));
    total++; if (wb_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d exp 4", wb_count); end
    cyc(0, 1, AW'('h30), N'('hCC));
    total++; if (wb_count !== 3'd4) begin bad++; $display("FAIL full_nr_count: got %0d exp 4", wb_count); end
    total++; if (wb_overflow !== 1'b0) begin bad++; $display("FAIL full_nr_ovf: got %b exp 0", wb_overflow); end
    repeat (6) cyc(0, 0, '0, '0);
    cyc(1, 0, AW'('h30), '0);
    total++; if (bus.MM_read_word !== N'('hCC)) begin bad++; $display("FAIL full_nr_data: got %h exp cc", bus.MM_read_word); end
    cyc(1, 0, AW'('h20), '0);
    total++; if (bus.MM_read_word !== N'('hC0)) begin bad++; $display("FAIL full_nr_head: got %h exp c0", bus.MM_read_word); end
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 3; i++) cyc(0, 1, AW'('h40 + i), N'('h700 + i));
    repeat (2) cyc(0, 0, '0, '0);
    for (int i = 0; i < 3; i++) cyc(1, 1, AW'('h40 + i), N'('hBAD0 + i));
    total++; if (wb_count !== 3'd3) begin bad++; $display("FAIL rst_pre_count: got %0d exp 3", wb_count); end
    rst_n = 1'b0;
    #1;
    total++; if (wb_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d exp 0", wb_count); end
    total++; if (bus.MM_read_word !== '0) begin bad++; $display("FAIL rst_rdata: got %h exp 0", bus.MM_read_word); end
    total++; if (MM_statistics !== '0) begin bad++; $display("FAIL rst_stats: got %h exp 0", MM_statistics); end
    rst_n = 1'b1;
    model_reset();
    repeat (5) cyc(0, 0, '0, '0);
    total++; if (wb_count !== 3'd0) begin bad++; $display("FAIL rst_post_count: got %0d exp 0", wb_count); end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, AW'('h40 + i), '0);
      total++;
      if (bus.MM_read_word !== N'('h700 + i)) begin
        bad++; $display("FAIL rst_discard%0d: got %h exp %h", i, bus.MM_read_word, N'('h700 + i));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_stats;
    bit rd, wr;
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) cyc(0, 1, AW'('h200 + i), N'($urandom));
    repeat (6) cyc(0, 0, '0, '0);
    for (int c = 0; c < 400; c++) begin
      rd = ($urandom_range(0, 9) < 6);
      wr = ($urandom_range(0, 1) == 1);
      a  = AW'('h200 + $urandom_range(0, 7));
      cyc(rd, wr, a, N'($urandom));
      if (m_rknown) begin
        total++;
        if (bus.MM_read_word !== m_rword) begin bad++; $display("FAIL rnd_rdata c%0d: got %h exp %h", c, bus.MM_read_word, m_rword); end
      end
      total++;
      if (int'(wb_count) != m_q.size()) begin bad++; $display("FAIL rnd_count c%0d: got %0d exp %0d", c, wb_count, m_q.size()); end
      total++;
      if (wb_overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf c%0d: got %b exp %b", c, wb_overflow, m_ovf); end
      exp_stats = {m_rc[15:0], m_wc[15:0]};
      total++;
      if (MM_statistics !== exp_stats) begin bad++; $display("FAIL rnd_stats c%0d: got %h exp %h", c, MM_statistics, exp_stats); end
    end
    total++; if (mm_parity_error !== 1'b0) begin bad++; $display("FAIL rnd_par: got %b exp 0", mm_parity_error); end
  endtask

`ifdef MM_PARITY_EN
  task automatic test_parity();
    cyc(0, 1, AW'('h80), N'('h1));
    repeat (2) cyc(0, 0, '0, '0);
    cyc(1, 0, AW'('h80), '0);
    total++; if (mm_parity_error !== 1'b0) begin bad++; $display("FAIL par_clean: got %b exp 0", mm_parity_error); end
    dut.r_par[10'h80] = ~dut.r_par[10'h80];
    cyc(1, 0, AW'('h80), '0);
    total++; if (mm_parity_error !== 1'b1) begin bad++; $display("FAIL par_detect: got %b exp 1", mm_parity_error); end
  endtask
`endif

  initial begin
    bus.MM_read_request  = 1'b0;
    bus.MM_write_request = 1'b0;
    bus.MM_word_address  = '0;
    bus.MM_write_word    = '0;
    for (int i = 0; i < (1 << AW); i++) m_known[i] = 1'b0;
    model_reset();
    test_reset();
    test_basic_read();
    test_refill_burst();
    test_forwarding();
    test_overflow();
    test_full_no_read();
    test_reset_mid_op();
    test_random();
`ifdef MM_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
